// File: rtl/tx_flow_scheduler.sv
// Round-robin batch scheduler: picks an eligible TX flow FIFO and issues a
// contiguous burst of 1/2/4 single-entry pops toward the CCI-P c1 write stage.
module tx_flow_scheduler #(
    parameter int LMAX_NUM_OF_FLOWS = 1,
    parameter int LFIFO_DEPTH       = 3
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic                                                start,
    input  logic [LMAX_NUM_OF_FLOWS-1:0]                        number_of_flows,
    input  logic [1:0]                                          l_tx_batch_size,
    input  logic [(2**LMAX_NUM_OF_FLOWS)*(LFIFO_DEPTH+1)-1:0]   flow_occupancy,
    input  logic                                                tx_almost_full,
    output logic [(2**LMAX_NUM_OF_FLOWS)-1:0]                   pop_en,
    output logic [LMAX_NUM_OF_FLOWS-1:0]                        pop_flow_id,
    output logic                                                pop_sop,
    output logic                                                pop_eop,
    output logic                                                busy,
    output logic [31:0]                                         batch_count,
    output logic [31:0]                                         stall_count,
    output logic [1:0]                                          state_dbg
);

    localparam int MAX_FLOWS = 2 ** LMAX_NUM_OF_FLOWS;
    localparam int OW        = LFIFO_DEPTH + 1;
    localparam int FW        = LMAX_NUM_OF_FLOWS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        ISSUE  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [FW-1:0]        flow_q, flow_d;
    logic [FW-1:0]        rr_q, rr_d;
    logic [2:0]           bsz_q, bsz_d;
    logic [2:0]           beat_q, beat_d;
    logic [2:0]           bsz_live;
    logic [MAX_FLOWS-1:0] elig;
    logic                 grant_found;
    logic [FW-1:0]        grant_id;
    logic [FW-1:0]        cand;

    logic [MAX_FLOWS-1:0] pop_en_d;
    logic [FW-1:0]        pop_flow_id_d;
    logic                 pop_sop_d;
    logic                 pop_eop_d;
    logic                 busy_d;
    logic [31:0]          batch_count_d;
    logic [31:0]          stall_count_d;

    function automatic logic [MAX_FLOWS-1:0] onehot(input logic [FW-1:0] id);
        logic [MAX_FLOWS-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Batch size 3 is clamped to 4 beats.
    always_comb begin
        case (l_tx_batch_size)
            2'd0:    bsz_live = 3'd1;
            2'd1:    bsz_live = 3'd2;
            default: bsz_live = 3'd4;
        endcase
    end

    always_comb begin
        elig = '0;
        for (int i = 0; i < MAX_FLOWS; i++) begin
            elig[i] = (FW'(i) <= number_of_flows) &&
                      ({3'b000, flow_occupancy[i*OW +: OW]} >= {{OW{1'b0}}, bsz_live});
        end
    end

    // Search starts one past the last grant and wraps back to rr_q itself.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= MAX_FLOWS; k++) begin
            cand = rr_q + FW'(k);
            if (!grant_found && elig[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // Outputs are computed for the next cycle and registered, so a grant
    // decided in ARB shows its first pop one cycle later.
    always_comb begin
        state_d       = state_q;
        flow_d        = flow_q;
        rr_d          = rr_q;
        bsz_d         = bsz_q;
        beat_d        = beat_q;
        pop_en_d      = '0;
        pop_flow_id_d = pop_flow_id;
        pop_sop_d     = 1'b0;
        pop_eop_d     = 1'b0;
        batch_count_d = batch_count;
        stall_count_d = stall_count;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (!start) begin
                    state_d = IDLE;
                end else if (grant_found) begin
                    if (tx_almost_full) begin
                        stall_count_d = stall_count + 32'd1;
                    end else begin
                        flow_d        = grant_id;
                        rr_d          = grant_id;
                        bsz_d         = bsz_live;
                        beat_d        = 3'd0;
                        state_d       = ISSUE;
                        pop_en_d      = onehot(grant_id);
                        pop_flow_id_d = grant_id;
                        pop_sop_d     = 1'b1;
                        pop_eop_d     = (bsz_live == 3'd1);
                    end
                end
            end
            ISSUE: begin
                if (beat_q == bsz_q - 3'd1) begin
                    batch_count_d = batch_count + 32'd1;
                    beat_d        = 3'd0;
                    state_d       = SETTLE;
                end else begin
                    beat_d        = beat_q + 3'd1;
                    pop_en_d      = onehot(flow_q);
                    pop_flow_id_d = flow_q;
                    pop_eop_d     = (beat_q + 3'd2 == bsz_q);
                end
            end
            SETTLE: begin
                if (beat_q == 3'd1) begin
                    beat_d  = 3'd0;
                    state_d = start ? ARB : IDLE;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ISSUE) || (state_d == SETTLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            flow_q      <= '0;
            rr_q        <= '1;
            bsz_q       <= 3'd1;
            beat_q      <= 3'd0;
            pop_en      <= '0;
            pop_flow_id <= '0;
            pop_sop     <= 1'b0;
            pop_eop     <= 1'b0;
            busy        <= 1'b0;
            batch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            state_q     <= state_d;
            flow_q      <= flow_d;
            rr_q        <= rr_d;
            bsz_q       <= bsz_d;
            beat_q      <= beat_d;
            pop_en      <= pop_en_d;
            pop_flow_id <= pop_flow_id_d;
            pop_sop     <= pop_sop_d;
            pop_eop     <= pop_eop_d;
            busy        <= busy_d;
            batch_count <= batch_count_d;
            stall_count <= stall_count_d;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_tx_flow_scheduler.sv
// Directed bench for tx_flow_scheduler: expected pop beats are queued as
// stimulus is applied and compared beat-by-beat as the DUT pops.
module tb_tx_flow_scheduler;

    localparam int LMAX      = 1;
    localparam int LFD       = 3;
    localparam int MAX_FLOWS = 2;
    localparam int FW        = 1;
    localparam int W         = MAX_FLOWS + FW + 2;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic                 start = 1'b0;
    logic [FW-1:0]        number_of_flows = '0;
    logic [1:0]           l_tx_batch_size = 2'd0;
    logic [3:0]           occ0 = 4'd0;
    logic [3:0]           occ1 = 4'd0;
    logic [7:0]           flow_occupancy;
    logic                 tx_almost_full = 1'b0;
    logic [MAX_FLOWS-1:0] pop_en;
    logic [FW-1:0]        pop_flow_id;
    logic                 pop_sop;
    logic                 pop_eop;
    logic                 busy;
    logic [31:0]          batch_count;
    logic [31:0]          stall_count;
    logic [1:0]           state_dbg;

    logic [W-1:0] exp_q[$];
    int           errors = 0;
    int           checks = 0;
    logic         pop_seen = 1'b0;
    int           bc_exp;

    assign flow_occupancy = {occ1, occ0};

    always #5 clk = ~clk;

    tx_flow_scheduler #(.LMAX_NUM_OF_FLOWS(LMAX), .LFIFO_DEPTH(LFD)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .number_of_flows(number_of_flows), .l_tx_batch_size(l_tx_batch_size),
        .flow_occupancy(flow_occupancy), .tx_almost_full(tx_almost_full),
        .pop_en(pop_en), .pop_flow_id(pop_flow_id), .pop_sop(pop_sop),
        .pop_eop(pop_eop), .busy(busy), .batch_count(batch_count),
        .stall_count(stall_count), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] beat(input int flow, input logic sop, input logic eop);
        logic [MAX_FLOWS-1:0] oh;
        oh       = '0;
        oh[flow] = 1'b1;
        return {oh, FW'(flow), sop, eop};
    endfunction

    task automatic push_batch(input int flow, input int n);
        for (int b = 0; b < n; b++) exp_q.push_back(beat(flow, b == 0, b == n - 1));
    endtask

    // One cycle: sample outputs at the falling edge and score any pop.
    task automatic tick();
        logic [W-1:0] obs;
        logic [W-1:0] exp;
        @(negedge clk);
        pop_seen = (pop_en != '0);
        if (pop_seen) begin
            obs = {pop_en, pop_flow_id, pop_sop, pop_eop};
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pop: observed=%0h expected=none", obs);
            end
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check("pop_beat", 32'(obs), 32'(exp));
            end
        end
    endtask

    // Called at a falling edge; reset takes effect without a clock.
    task automatic apply_reset(input string tag);
        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        check({tag, "_pop_en"}, 32'(pop_en), 32'd0);
        check({tag, "_sop_eop"}, {30'd0, pop_sop, pop_eop}, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_batch"}, batch_count, 32'd0);
        check({tag, "_stall"}, stall_count, 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
        tick();
        tick();
        exp_q.delete();
        reset_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);

        // Single flow, batch 1: one pop every 4 cycles
        apply_reset("rst1");
        check("rst1_flow_id", 32'(pop_flow_id), 32'd0);
        number_of_flows = 1'b0; l_tx_batch_size = 2'd0; occ0 = 4'd3; occ1 = 4'd0;
        start = 1'b1;
        push_batch(0, 1); push_batch(0, 1); push_batch(0, 1);
        bc_exp = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1) check("t1_state_arb", 32'(state_dbg), 32'd1);
            check("t1_pop_cycle", 32'(pop_seen), 32'((i <= 10) && (i % 4 == 2)));
            check("t1_busy", 32'(busy), 32'((i >= 2) && (i <= 12) && (i % 4 != 1)));
            check("t1_batch", batch_count, 32'(bc_exp));
            if (pop_seen) bc_exp++;
            if (i == 10) occ0 = 4'd0;
        end
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Round-robin over two flows, batch 4
        apply_reset("rst2");
        number_of_flows = 1'b1; l_tx_batch_size = 2'd2; occ0 = 4'd7; occ1 = 4'd7;
        start = 1'b1;
        push_batch(0, 4); push_batch(1, 4); push_batch(0, 4); push_batch(1, 4);
        for (int i = 1; i <= 30; i++) begin
            tick();
            check("t2_pop_cycle", 32'(pop_seen), 32'((i >= 2) && (i <= 26) && ((i - 2) % 7 < 4)));
            if (i == 26) begin occ0 = 4'd0; occ1 = 4'd0; end
        end
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t2_batch", batch_count, 32'd4);

        // Masking and the occupancy threshold boundary
        apply_reset("rst3");
        number_of_flows = 1'b0; l_tx_batch_size = 2'd2; occ0 = 4'd3; occ1 = 4'd7;
        start = 1'b1;
        bc_exp = 0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (pop_seen) bc_exp++;
        end
        check("t3_masked_pops", 32'(bc_exp), 32'd0);
        occ0 = 4'd4;
        push_batch(0, 4);
        tick();
        check("t3_occ_eq_size_grant", 32'(pop_seen), 32'd1);
        occ0 = 4'd0;
        for (int i = 0; i < 8; i++) tick();
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t3_batch", batch_count, 32'd1);

        // Almost-full stalls, then a batch that ignores almost-full
        apply_reset("rst4");
        number_of_flows = 1'b0; l_tx_batch_size = 2'd2; occ0 = 4'd7; occ1 = 4'd0;
        tx_almost_full = 1'b1;
        start = 1'b1;
        tick();
        check("t4_stall_start", stall_count, 32'd0);
        for (int i = 2; i <= 11; i++) begin
            tick();
            check("t4_no_pop_af", 32'(pop_seen), 32'd0);
        end
        check("t4_stall_10", stall_count, 32'd10);
        tx_almost_full = 1'b0;
        push_batch(0, 4);
        tick();
        check("t4_pop_after_af", 32'(pop_seen), 32'd1);
        tx_almost_full = 1'b1;
        for (int i = 13; i <= 20; i++) begin
            tick();
            check("t4_pop_cycle", 32'(pop_seen), 32'(i <= 15));
            if (i == 15) begin occ0 = 4'd0; tx_almost_full = 1'b0; end
        end
        check("t4_stall_final", stall_count, 32'd10);
        check("t4_batch", batch_count, 32'd1);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Batch size change mid-batch; size code 3 behaves as 4
        apply_reset("rst5");
        number_of_flows = 1'b0; l_tx_batch_size = 2'd2; occ0 = 4'd7; occ1 = 4'd0;
        start = 1'b1;
        push_batch(0, 4); push_batch(0, 1); push_batch(0, 4);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("t5_pop_cycle", 32'(pop_seen),
                  32'(((i >= 2) && (i <= 5)) || (i == 9) || ((i >= 15) && (i <= 18))));
            if (i == 3) l_tx_batch_size = 2'd0;
            if (i == 9) occ0 = 4'd0;
            if (i == 14) begin l_tx_batch_size = 2'd3; occ0 = 4'd7; end
            if (i == 15) occ0 = 4'd0;
        end
        check("t5_batch", batch_count, 32'd3);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during beat 2 of a batch
        apply_reset("rst6");
        number_of_flows = 1'b1; l_tx_batch_size = 2'd2; occ0 = 4'd7; occ1 = 4'd7;
        tx_almost_full = 1'b1;
        start = 1'b1;
        push_batch(0, 4); push_batch(1, 4);
        for (int i = 1; i <= 13; i++) begin
            tick();
            check("t6_pop_cycle", 32'(pop_seen), 32'(((i >= 4) && (i <= 7)) || (i >= 11)));
            if (i == 3) tx_almost_full = 1'b0;
        end
        check("t6_batch_pre", batch_count, 32'd1);
        check("t6_stall_pre", stall_count, 32'd2);
        check("t6_flow_pre", 32'(pop_flow_id), 32'd1);
        apply_reset("t6_midbatch");
        start = 1'b1;
        push_batch(0, 4);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("t6_post_pop_cycle", 32'(pop_seen), 32'((i >= 2) && (i <= 5)));
            if (i == 2) begin occ0 = 4'd0; occ1 = 4'd0; end
        end
        check("t6_batch_post", batch_count, 32'd1);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        start = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
